// File: rtl/song_sequencer.sv
// song_sequencer: playback controller for the music-player datapath.
// Runs the IDLE/PLAY/PAUSE/END state machine, owns the song index and the
// note-address counter, and produces the tone enable, note strobe and
// end-of-song pulse. All outputs are registered.
// Optional feature macro: SONG_SEQ_AUTO_ADVANCE_EN
//   defined   -> END moves on to the next song and keeps playing
//   undefined -> END returns to IDLE on the same song
module song_sequencer #(
  parameter int NUM_SONGS = 3,
  parameter int SEL_W     = 2,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_4hz,
  input  logic              start_p,
  input  logic              stop_p,
  input  logic              next_p,
  input  logic              song_end,
  output logic [SEL_W-1:0]  song_sel,
  output logic [ADDR_W-1:0] note_addr,
  output logic              tone_en,
  output logic              note_strobe,
  output logic              done_p,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_END   = 2'b11
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_SONGS - 1);

  // Song index advance; wraps at the last song so no out-of-range index appears.
  function automatic logic [SEL_W-1:0] sel_advance(input logic [SEL_W-1:0] s);
    if (s == SEL_LAST) return '0;
    else               return s + SEL_W'(1);
  endfunction

  state_t            r_state;
  logic [SEL_W-1:0]  r_song_sel;
  logic [ADDR_W-1:0] r_note_addr;
  logic              r_tone_en;
  logic              r_note_strobe;
  logic              r_done_p;

  state_t            w_state_nxt;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_tone_nxt;
  logic              w_strobe_nxt;
  logic              w_done_nxt;

  // State and output registers; async reset returns everything to idle values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_song_sel    <= '0;
      r_note_addr   <= '0;
      r_tone_en     <= 1'b0;
      r_note_strobe <= 1'b0;
      r_done_p      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_song_sel    <= w_sel_nxt;
      r_note_addr   <= w_addr_nxt;
      r_tone_en     <= w_tone_nxt;
      r_note_strobe <= w_strobe_nxt;
      r_done_p      <= w_done_nxt;
    end
  end

  // Next-state and next-output logic. Events that a state ignores are skipped,
  // so the highest-priority event that actually applies is the one that acts.
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_song_sel;
    w_addr_nxt   = r_note_addr;
    w_strobe_nxt = 1'b0;
    w_done_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (next_p) begin
          w_sel_nxt = sel_advance(r_song_sel);
        end else if (start_p) begin
          w_state_nxt  = ST_PLAY;
          w_addr_nxt   = '0;
          w_strobe_nxt = 1'b1;
        end
      end

      ST_PLAY: begin
        if (stop_p) begin
          w_state_nxt = ST_PAUSE;
        end else if (next_p) begin
          w_sel_nxt    = sel_advance(r_song_sel);
          w_addr_nxt   = '0;
          w_strobe_nxt = 1'b1;
        end else if (tick_4hz) begin
          // The counter never wraps: the last address ends the song.
          if (song_end || (r_note_addr == ADDR_LAST)) begin
            w_state_nxt = ST_END;
            w_done_nxt  = 1'b1;
          end else begin
            w_addr_nxt   = r_note_addr + ADDR_W'(1);
            w_strobe_nxt = 1'b1;
          end
        end
      end

      ST_PAUSE: begin
        if (stop_p) begin
          w_state_nxt = ST_IDLE;
          w_addr_nxt  = '0;
        end else if (next_p) begin
          w_sel_nxt  = sel_advance(r_song_sel);
          w_addr_nxt = '0;
        end else if (start_p) begin
          w_state_nxt  = ST_PLAY;
          w_strobe_nxt = 1'b1;
        end
      end

      ST_END: begin
`ifdef SONG_SEQ_AUTO_ADVANCE_EN
        w_state_nxt  = ST_PLAY;
        w_sel_nxt    = sel_advance(r_song_sel);
        w_addr_nxt   = '0;
        w_strobe_nxt = 1'b1;
`else
        w_state_nxt = ST_IDLE;
        w_addr_nxt  = '0;
`endif
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_addr_nxt  = '0;
      end
    endcase

    w_tone_nxt = (w_state_nxt == ST_PLAY);
  end

  assign state       = r_state;
  assign song_sel    = r_song_sel;
  assign note_addr   = r_note_addr;
  assign tone_en     = r_tone_en;
  assign note_strobe = r_note_strobe;
  assign done_p      = r_done_p;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: a default instance plus a 3-bit address
// instance for the address-saturation case. Expected values are hand-derived.
module tb_song_sequencer;

  logic clk = 1'b0;
  logic reset;

  // Default-parameter instance signals
  logic       tick_4hz, start_p, stop_p, next_p, song_end;
  logic [1:0] song_sel;
  logic [7:0] note_addr;
  logic       tone_en, note_strobe, done_p;
  logic [1:0] state;

  // ADDR_W=3 instance signals
  logic       s_tick, s_start, s_stop, s_next, s_end;
  logic [1:0] s_song_sel;
  logic [2:0] s_note_addr;
  logic       s_tone_en, s_note_strobe, s_done_p;
  logic [1:0] s_state;

  int total = 0;
  int bad   = 0;
  int exp_sel;

  always #5 clk = ~clk;

  song_sequencer #(.NUM_SONGS(3), .SEL_W(2), .ADDR_W(8)) u_dut (
    .clk(clk), .reset(reset), .tick_4hz(tick_4hz), .start_p(start_p),
    .stop_p(stop_p), .next_p(next_p), .song_end(song_end),
    .song_sel(song_sel), .note_addr(note_addr), .tone_en(tone_en),
    .note_strobe(note_strobe), .done_p(done_p), .state(state)
  );

  song_sequencer #(.NUM_SONGS(3), .SEL_W(2), .ADDR_W(3)) u_small (
    .clk(clk), .reset(reset), .tick_4hz(s_tick), .start_p(s_start),
    .stop_p(s_stop), .next_p(s_next), .song_end(s_end),
    .song_sel(s_song_sel), .note_addr(s_note_addr), .tone_en(s_tone_en),
    .note_strobe(s_note_strobe), .done_p(s_done_p), .state(s_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int sel, input int addr,
                         input int ton, input int strb, input int dn);
    chk({tag, ".state"},  32'(state),       32'(st));
    chk({tag, ".sel"},    32'(song_sel),    32'(sel));
    chk({tag, ".addr"},   32'(note_addr),   32'(addr));
    chk({tag, ".tone"},   32'(tone_en),     32'(ton));
    chk({tag, ".strobe"}, 32'(note_strobe), 32'(strb));
    chk({tag, ".done"},   32'(done_p),      32'(dn));
  endtask

  task automatic chk_small(input string tag, input int st, input int sel, input int addr,
                           input int strb, input int dn);
    chk({tag, ".state"},  32'(s_state),       32'(st));
    chk({tag, ".sel"},    32'(s_song_sel),    32'(sel));
    chk({tag, ".addr"},   32'(s_note_addr),   32'(addr));
    chk({tag, ".strobe"}, 32'(s_note_strobe), 32'(strb));
    chk({tag, ".done"},   32'(s_done_p),      32'(dn));
  endtask

  // One clock with the given pulses on the default instance; returns #1 after the edge.
  task automatic cyc(input logic st, input logic sp, input logic nx, input logic tk, input logic se);
    start_p = st; stop_p = sp; next_p = nx; tick_4hz = tk; song_end = se;
    @(posedge clk);
    #1;
    start_p = 1'b0; stop_p = 1'b0; next_p = 1'b0; tick_4hz = 1'b0; song_end = 1'b0;
  endtask

  task automatic cyc_s(input logic st, input logic tk);
    s_start = st; s_tick = tk;
    @(posedge clk);
    #1;
    s_start = 1'b0; s_tick = 1'b0;
  endtask

  // Watchdog: the directed sequence is short, so a long stall is a fault.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    tick_4hz = 0; start_p = 0; stop_p = 0; next_p = 0; song_end = 0;
    s_tick = 0; s_start = 0; s_stop = 0; s_next = 0; s_end = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(0, 0, 0, 1, 0);
    chk_all("idle_tick", 0, 0, 0, 0, 0, 0);

    // Start and three ticks
    cyc(1, 0, 0, 0, 0); chk_all("start", 1, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0); chk_all("tick1", 1, 0, 1, 1, 1, 0);
    cyc(0, 0, 0, 1, 0); chk_all("tick2", 1, 0, 2, 1, 1, 0);
    cyc(0, 0, 0, 1, 0); chk_all("tick3", 1, 0, 3, 1, 1, 0);
    cyc(0, 0, 0, 0, 0); chk_all("hold3", 1, 0, 3, 1, 0, 0);
    cyc(1, 0, 0, 1, 0); chk_all("start_tick", 1, 0, 4, 1, 1, 0);
    cyc(0, 0, 0, 1, 0); chk_all("tick5", 1, 0, 5, 1, 1, 0);

    // Pause / resume / stop
    cyc(0, 1, 0, 0, 0); chk_all("pause", 2, 0, 5, 0, 0, 0);
    cyc(0, 0, 0, 1, 0); chk_all("pause_tick", 2, 0, 5, 0, 0, 0);
    cyc(1, 0, 0, 0, 0); chk_all("resume", 1, 0, 5, 1, 1, 0);
    cyc(0, 1, 0, 0, 0); chk_all("pause2", 2, 0, 5, 0, 0, 0);
    cyc(0, 1, 0, 0, 0); chk_all("stop_idle", 0, 0, 0, 0, 0, 0);

    // Song select wrap in IDLE
    cyc(0, 0, 1, 0, 0); chk_all("next1", 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); chk_all("next2", 0, 2, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); chk_all("next_wrap", 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); chk_all("next_to1", 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0); chk_all("start_s1", 1, 1, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0); chk_all("tick_s1", 1, 1, 1, 1, 1, 0);
    cyc(0, 1, 1, 0, 0); chk_all("stop_beats_next", 2, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0); chk_all("stop_s1", 0, 1, 0, 0, 0, 0);

    // Next in PLAY restarts at address 0 on the next song
    cyc(1, 0, 0, 0, 0); chk_all("start_s1b", 1, 1, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0); chk_all("tick_s1b", 1, 1, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 0); chk_all("play_next", 1, 2, 0, 1, 1, 0);

    // End of song on song 2
    cyc(0, 0, 0, 1, 0); chk_all("tick_s2", 1, 2, 1, 1, 1, 0);
    cyc(0, 0, 0, 1, 1); chk_all("end", 3, 2, 1, 0, 0, 1);
    cyc(1, 1, 1, 1, 1);
`ifdef SONG_SEQ_AUTO_ADVANCE_EN
    chk_all("end_exit", 1, 0, 0, 1, 1, 0);
    exp_sel = 0;
`else
    chk_all("end_exit", 0, 2, 0, 0, 0, 0);
    exp_sel = 2;
`endif

    // Async reset mid-PLAY at note_addr 4
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk_all("back_idle", 0, exp_sel, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk_all("pre_reset", 1, exp_sel, 4, 1, 1, 0);
    #2 reset = 1'b1;
    #1 chk_all("async_reset", 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    cyc(0, 0, 0, 1, 0); chk_all("post_reset", 0, 0, 0, 0, 0, 0);

    // 3-bit address: saturation at 7 forces END
    cyc_s(1, 0); chk_small("s_start", 1, 0, 0, 1, 0);
    for (int i = 1; i <= 7; i++) begin
      cyc_s(0, 1);
      chk_small("s_tick", 1, 0, i, 1, 0);
    end
    cyc_s(0, 1); chk_small("s_end", 3, 0, 7, 0, 1);
    cyc_s(0, 0);
`ifdef SONG_SEQ_AUTO_ADVANCE_EN
    chk_small("s_exit", 1, 1, 0, 1, 0);
`else
    chk_small("s_exit", 0, 0, 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
